decode_stage: RTL and testbench

- Registered, parametrised RV32I/RV32E instruction-decode pipeline stage.
- Sits between fetch and execute; the input and output sides each use a valid/ready handshake.
- Covers the full base opcode set: OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR. Adds illegal-instruction detection, flush and a 2-entry skid buffer so back-pressure never forms a combinational ready path.

---
 rtl/decode_stage_pkg.sv | 47 ++++
 rtl/decode_comb.sv | 152 +++++++++++++++
 rtl/decode_stage.sv | 150 +++++++++++++++
 tb/tb_decode_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
//   Shared constants and types for the RV32I/RV32E decode stage.
//   - base opcode encodings (inst[6:0])
//   - ALU operation encodings, {inst[30], funct3} style
//   - ctrl_t: the width-independent control part of a decoded bundle
package decode_stage_pkg;

  localparam int INST_W   = 32;
  localparam int FUNCT3_W = 3;
  localparam int ALU_OP_W = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1101;

  typedef struct packed {
    logic                  write_en;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [FUNCT3_W-1:0]   funct3;
    logic [ALU_OP_W-1:0]   alu_opcode;
    logic                  alu_src_from_imm;
    logic                  alu_src_from_pc;
    logic                  branch_inst;
    logic                  jump_inst;
    logic                  jalr_inst;
    logic                  illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// decode_comb
//   Purely combinational RV32I/RV32E instruction decoder.
//   Ports:
//     inst       in   32      instruction word
//     ctrl       out  ctrl_t  enables, ALU select, illegal flag
//     immediate  out  XLEN    sign-extended immediate (0 when unused)
//     rd/rs1/rs2 out  REG_AW  register fields (rs1 forced to 0 for LUI)
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic [INST_W-1:0] inst,
  output ctrl_t             ctrl,
  output logic [XLEN-1:0]   immediate,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm32;
  logic [4:0]  rs1_field;
  logic        use_rd, use_rs1, use_rs2;
  logic        bad;

  always_comb begin
    opcode    = inst[6:0];
    f3        = inst[14:12];
    f7        = inst[31:25];
    ctrl      = '0;
    ctrl.funct3 = f3;
    imm32     = '0;
    rs1_field = inst[19:15];
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    bad       = 1'b0;

    if (inst[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          ctrl.write_en   = 1'b1;
          ctrl.alu_opcode = {inst[30], f3};
          use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
          // Only SUB and SRA exist with the alternate funct7.
          if (f7 == 7'b0100000)
            bad = !(f3 == 3'b000 || f3 == 3'b101);
          else if (f7 != 7'b0000000)
            bad = 1'b1;
        end
        OPC_OP_IMM: begin
          ctrl.write_en         = 1'b1;
          ctrl.alu_src_from_imm = 1'b1;
          imm32  = {{20{inst[31]}}, inst[31:20]};
          use_rd = 1'b1; use_rs1 = 1'b1;
          // inst[30] only selects SRAI; elsewhere it is immediate data.
          if (f3 == 3'b101) begin
            ctrl.alu_opcode = {inst[30], 3'b101};
            bad = !(f7 == 7'b0000000 || f7 == 7'b0100000);
          end else begin
            ctrl.alu_opcode = {1'b0, f3};
            if (f3 == 3'b001)
              bad = (f7 != 7'b0000000);
          end
        end
        OPC_LOAD: begin
          ctrl.write_en    = 1'b1;
          ctrl.mem_read_en = 1'b1;
          ctrl.alu_opcode  = ALU_ADD;
          imm32  = {{20{inst[31]}}, inst[31:20]};
          use_rd = 1'b1; use_rs1 = 1'b1;
          bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        OPC_STORE: begin
          ctrl.mem_write_en = 1'b1;
          ctrl.alu_opcode   = ALU_ADD;
          imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
          use_rs1 = 1'b1; use_rs2 = 1'b1;
          bad = (f3 >= 3'b011);
        end
        OPC_BRANCH: begin
          ctrl.branch_inst = 1'b1;
          ctrl.alu_opcode  = ALU_SUB;
          imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
          use_rs1 = 1'b1; use_rs2 = 1'b1;
          bad = (f3 == 3'b010) || (f3 == 3'b011);
        end
        OPC_LUI: begin
          ctrl.write_en         = 1'b1;
          ctrl.alu_opcode       = ALU_ADD;
          ctrl.alu_src_from_imm = 1'b1;
          imm32     = {inst[31:12], 12'b0};
          // x0 + imm lets the ALU produce the LUI result unchanged.
          rs1_field = 5'd0;
          use_rd    = 1'b1;
        end
        OPC_AUIPC: begin
          ctrl.write_en         = 1'b1;
          ctrl.alu_opcode       = ALU_ADD;
          ctrl.alu_src_from_imm = 1'b1;
          ctrl.alu_src_from_pc  = 1'b1;
          imm32  = {inst[31:12], 12'b0};
          use_rd = 1'b1;
        end
        OPC_JAL: begin
          ctrl.write_en        = 1'b1;
          ctrl.jump_inst       = 1'b1;
          ctrl.alu_src_from_pc = 1'b1;
          imm32  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
          use_rd = 1'b1;
        end
        OPC_JALR: begin
          ctrl.write_en        = 1'b1;
          ctrl.jump_inst       = 1'b1;
          ctrl.jalr_inst       = 1'b1;
          ctrl.alu_src_from_pc = 1'b1;
          imm32  = {{20{inst[31]}}, inst[31:20]};
          use_rd = 1'b1; use_rs1 = 1'b1;
          bad = (f3 != 3'b000);
        end
        default: bad = 1'b1;
      endcase
    end

    // RV32E: x16..x31 do not exist, so any used register with bit 4 set traps.
    if (NUM_REGS < 32)
      bad = bad || (use_rd && inst[11]) || (use_rs1 && inst[19]) || (use_rs2 && inst[24]);

    if (bad) begin
      ctrl.illegal      = 1'b1;
      ctrl.write_en     = 1'b0;
      ctrl.mem_read_en  = 1'b0;
      ctrl.mem_write_en = 1'b0;
      ctrl.branch_inst  = 1'b0;
      ctrl.jump_inst    = 1'b0;
      ctrl.jalr_inst    = 1'b0;
    end

    immediate = XLEN'(signed'(imm32));
    rd        = inst[7 +: REG_AW];
    rs1       = rs1_field[REG_AW-1:0];
    rs2       = inst[20 +: REG_AW];
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Registered decode pipeline stage between fetch and execute.
//   Ports:
//     clk, rst_n              clock (rising edge), async active-low reset
//     flush                   drop held and incoming instructions
//     in_valid/in_ready       fetch-side handshake; in_inst, in_pc payload
//     out_valid/out_ready     execute-side handshake
//     out_pc ... illegal      decoded bundle, held stable while stalled
//   SKID=1: 2-entry buffer (output + skid), in_ready depends on state only.
//   SKID=0: single output register, in_ready = !out_valid || out_ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int SKID     = 1,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_W-1:0]   in_inst,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic                write_en,
  output logic [REG_AW-1:0]   write_addr,
  output logic [REG_AW-1:0]   read_addr1,
  output logic [REG_AW-1:0]   read_addr2,
  output logic [XLEN-1:0]     immediate,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic [FUNCT3_W-1:0] funct3,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic                alu_src_from_imm,
  output logic                alu_src_from_pc,
  output logic                branch_inst,
  output logic                jump_inst,
  output logic                jalr_inst,
  output logic                illegal
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    ctrl_t             ctrl;
  } entry_t;

  ctrl_t             dec_ctrl;
  logic [XLEN-1:0]   dec_imm;
  logic [REG_AW-1:0] dec_rd, dec_rs1, dec_rs2;
  entry_t            dec;

  entry_t out_reg, out_next, skid_reg, skid_next;
  logic   out_valid_reg, out_valid_next, skid_valid_reg, skid_valid_next;
  logic   accept, out_free;

  decode_comb #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_decode (
    .inst      (in_inst),
    .ctrl      (dec_ctrl),
    .immediate (dec_imm),
    .rd        (dec_rd),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2)
  );

  assign dec = '{pc: in_pc, imm: dec_imm, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, ctrl: dec_ctrl};

  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = !skid_valid_reg;
    end else begin : g_direct_ready
      assign in_ready = !out_valid_reg || out_ready;
    end
  endgenerate

  // A handshake during flush is still discarded.
  assign accept   = in_valid && in_ready && !flush;
  assign out_free = !out_valid_reg || out_ready;

  always_comb begin
    out_next        = out_reg;
    out_valid_next  = out_valid_reg;
    skid_next       = skid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (out_free) begin
      // The skid entry is older than anything arriving, so it goes first.
      // in_ready is low while the skid is full, so no accept can collide.
      if (SKID != 0 && skid_valid_reg) begin
        out_next        = skid_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_next       = dec;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (SKID != 0 && accept) begin
      skid_next       = dec;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg        <= '0;
      out_valid_reg  <= 1'b0;
      skid_reg       <= '0;
      skid_valid_reg <= 1'b0;
    end else begin
      out_reg        <= out_next;
      out_valid_reg  <= out_valid_next;
      skid_reg       <= skid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  assign out_valid        = out_valid_reg;
  assign out_pc           = out_reg.pc;
  assign immediate        = out_reg.imm;
  assign write_addr       = out_reg.rd;
  assign read_addr1       = out_reg.rs1;
  assign read_addr2       = out_reg.rs2;
  assign write_en         = out_reg.ctrl.write_en;
  assign mem_read_en      = out_reg.ctrl.mem_read_en;
  assign mem_write_en     = out_reg.ctrl.mem_write_en;
  assign funct3           = out_reg.ctrl.funct3;
  assign alu_opcode       = out_reg.ctrl.alu_opcode;
  assign alu_src_from_imm = out_reg.ctrl.alu_src_from_imm;
  assign alu_src_from_pc  = out_reg.ctrl.alu_src_from_pc;
  assign branch_inst      = out_reg.ctrl.branch_inst;
  assign jump_inst        = out_reg.ctrl.jump_inst;
  assign jalr_inst        = out_reg.ctrl.jalr_inst;
  assign illegal          = out_reg.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed bench for decode_stage: an RV32I/SKID=1 instance and an
//   RV32E instance sharing clock and reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready, out_valid, write_en, mem_read_en, mem_write_en;
  logic        alu_src_from_imm, alu_src_from_pc, branch_inst, jump_inst, jalr_inst, illegal;
  logic [31:0] out_pc, immediate;
  logic [4:0]  write_addr, read_addr1, read_addr2;
  logic [2:0]  funct3;
  logic [3:0]  alu_opcode;

  logic        e_flush = 1'b0;
  logic        e_in_valid = 1'b0;
  logic        e_out_ready = 1'b0;
  logic [31:0] e_in_inst = '0;
  logic [31:0] e_in_pc = '0;
  logic        e_in_ready, e_out_valid, e_write_en, e_mem_read_en, e_mem_write_en;
  logic        e_alu_src_from_imm, e_alu_src_from_pc, e_branch_inst, e_jump_inst, e_jalr_inst, e_illegal;
  logic [31:0] e_out_pc, e_immediate;
  logic [3:0]  e_write_addr, e_read_addr1, e_read_addr2;
  logic [2:0]  e_funct3;
  logic [3:0]  e_alu_opcode;

  int check_cnt = 0;
  int pass_cnt  = 0;

  initial forever #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NUM_REGS(32), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .write_en(write_en), .write_addr(write_addr), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .immediate(immediate), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .funct3(funct3), .alu_opcode(alu_opcode), .alu_src_from_imm(alu_src_from_imm),
    .alu_src_from_pc(alu_src_from_pc), .branch_inst(branch_inst), .jump_inst(jump_inst),
    .jalr_inst(jalr_inst), .illegal(illegal)
  );

  decode_stage #(.XLEN(32), .NUM_REGS(16), .SKID(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .flush(e_flush),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_inst(e_in_inst), .in_pc(e_in_pc),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_pc(e_out_pc),
    .write_en(e_write_en), .write_addr(e_write_addr), .read_addr1(e_read_addr1), .read_addr2(e_read_addr2),
    .immediate(e_immediate), .mem_read_en(e_mem_read_en), .mem_write_en(e_mem_write_en),
    .funct3(e_funct3), .alu_opcode(e_alu_opcode), .alu_src_from_imm(e_alu_src_from_imm),
    .alu_src_from_pc(e_alu_src_from_pc), .branch_inst(e_branch_inst), .jump_inst(e_jump_inst),
    .jalr_inst(e_jalr_inst), .illegal(e_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one cycle with the output side draining.
  task automatic send_one(input logic [31:0] inst, input logic [31:0] pc);
    in_inst   = inst;
    in_pc     = pc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    $display("xfer inst=%h pc=%h -> valid=%0b rd=%0d imm=%h alu=%b ill=%0b",
             inst, pc, out_valid, write_addr, immediate, alu_opcode, illegal);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else pass_cnt++;
    check_cnt++; if (write_en !== 1'b0) $display("FAIL reset_write_en: got %0b want 0", write_en); else pass_cnt++;
    check_cnt++; if (immediate !== 32'h0) $display("FAIL reset_immediate: got %h want 0", immediate); else pass_cnt++;
    check_cnt++; if (e_out_valid !== 1'b0) $display("FAIL reset_e_out_valid: got %0b want 0", e_out_valid); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    in_inst = 32'hFFF08293; in_pc = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL addi_in_ready: got %0b want 1", in_ready); else pass_cnt++;
    tick();
    in_valid = 1'b0;
    $display("xfer addi -> valid=%0b rd=%0d imm=%h", out_valid, write_addr, immediate);
    check_cnt++; if (out_valid !== 1'b1) $display("FAIL addi_valid: got %0b want 1", out_valid); else pass_cnt++;
    check_cnt++; if (write_addr !== 5'd5) $display("FAIL addi_rd: got %0d want 5", write_addr); else pass_cnt++;
    check_cnt++; if (read_addr1 !== 5'd1) $display("FAIL addi_rs1: got %0d want 1", read_addr1); else pass_cnt++;
    check_cnt++; if (immediate !== 32'hFFFFFFFF) $display("FAIL addi_imm: got %h want ffffffff", immediate); else pass_cnt++;
    check_cnt++; if (alu_opcode !== 4'b0000) $display("FAIL addi_alu: got %b want 0000", alu_opcode); else pass_cnt++;
    check_cnt++; if (alu_src_from_imm !== 1'b1) $display("FAIL addi_src_imm: got %0b want 1", alu_src_from_imm); else pass_cnt++;
    check_cnt++; if (write_en !== 1'b1) $display("FAIL addi_write_en: got %0b want 1", write_en); else pass_cnt++;
    tick();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL addi_drained: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int          got_rd[$];
    logic [31:0] got_pc[$];
    logic [4:0]  exp_rd;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst = 32'h00100093; in_pc = 32'h10;      // addi x1,x0,1
    tick();
    in_inst = 32'h00200113; in_pc = 32'h14;      // addi x2,x0,2
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL bb_ready_2nd: got %0b want 1", in_ready); else pass_cnt++;
    tick();
    in_inst = 32'h00300193; in_pc = 32'h18;      // addi x3,x0,3
    check_cnt++; if (in_ready !== 1'b0) $display("FAIL bb_ready_3rd: got %0b want 0", in_ready); else pass_cnt++;
    tick();
    check_cnt++; if (out_valid !== 1'b1 || write_addr !== 5'd1) $display("FAIL bb_hold: got valid=%0b rd=%0d want 1/1", out_valid, write_addr); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b0) $display("FAIL bb_ready_stalled: got %0b want 0", in_ready); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      automatic logic fire = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_rd.push_back(int'(write_addr));
        got_pc.push_back(out_pc);
        $display("xfer bb out rd=%0d pc=%h imm=%h", write_addr, out_pc, immediate);
      end
      tick();
      if (fire) in_valid = 1'b0;
    end
    check_cnt++; if (got_rd.size() != 3) $display("FAIL bb_count: got %0d want 3", got_rd.size()); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      exp_rd = 5'(k + 1);
      check_cnt++;
      if (k >= got_rd.size() || got_rd[k] != int'(exp_rd) || got_pc[k] !== 32'h10 + 32'(4 * k))
        $display("FAIL bb_order_%0d: got rd=%0d pc=%h want rd=%0d pc=%h", k,
                 (k < got_rd.size()) ? got_rd[k] : -1, (k < got_pc.size()) ? got_pc[k] : 32'hx,
                 exp_rd, 32'h10 + 32'(4 * k));
      else pass_cnt++;
    end
  endtask

  task automatic test_jal();
    send_one(32'h001000EF, 32'h100);             // jal x1,+2048
    check_cnt++; if (out_valid !== 1'b1) $display("FAIL jal_valid: got %0b want 1", out_valid); else pass_cnt++;
    check_cnt++; if (jump_inst !== 1'b1) $display("FAIL jal_jump: got %0b want 1", jump_inst); else pass_cnt++;
    check_cnt++; if (immediate !== 32'h800) $display("FAIL jal_imm: got %h want 00000800", immediate); else pass_cnt++;
    check_cnt++; if (alu_src_from_pc !== 1'b1) $display("FAIL jal_src_pc: got %0b want 1", alu_src_from_pc); else pass_cnt++;
    check_cnt++; if (out_pc !== 32'h100) $display("FAIL jal_pc: got %h want 00000100", out_pc); else pass_cnt++;
    check_cnt++; if (write_addr !== 5'd1 || jalr_inst !== 1'b0) $display("FAIL jal_rd_jalr: got rd=%0d jalr=%0b want 1/0", write_addr, jalr_inst); else pass_cnt++;
  endtask

  task automatic test_formats();
    send_one(32'h0020A423, 32'h200);             // sw x2,8(x1)
    check_cnt++; if (mem_write_en !== 1'b1 || write_en !== 1'b0) $display("FAIL sw_en: got mw=%0b we=%0b want 1/0", mem_write_en, write_en); else pass_cnt++;
    check_cnt++; if (immediate !== 32'h8 || read_addr2 !== 5'd2) $display("FAIL sw_imm_rs2: got imm=%h rs2=%0d want 8/2", immediate, read_addr2); else pass_cnt++;
    send_one(32'h00208463, 32'h204);             // beq x1,x2,+8
    check_cnt++; if (branch_inst !== 1'b1 || alu_opcode !== 4'b1000) $display("FAIL beq_ctrl: got br=%0b alu=%b want 1/1000", branch_inst, alu_opcode); else pass_cnt++;
    check_cnt++; if (immediate !== 32'h8) $display("FAIL beq_imm: got %h want 8", immediate); else pass_cnt++;
    send_one(32'h123452B7, 32'h208);             // lui x5,0x12345
    check_cnt++; if (immediate !== 32'h12345000) $display("FAIL lui_imm: got %h want 12345000", immediate); else pass_cnt++;
    check_cnt++; if (read_addr1 !== 5'd0 || alu_src_from_imm !== 1'b1) $display("FAIL lui_rs1_src: got rs1=%0d imm_src=%0b want 0/1", read_addr1, alu_src_from_imm); else pass_cnt++;
  endtask

  task automatic test_illegal();
    send_one(32'h0000707F, 32'h300);             // unknown opcode
    check_cnt++; if (out_valid !== 1'b1 || illegal !== 1'b1) $display("FAIL ill_opc: got valid=%0b ill=%0b want 1/1", out_valid, illegal); else pass_cnt++;
    check_cnt++; if (write_en !== 1'b0) $display("FAIL ill_opc_we: got %0b want 0", write_en); else pass_cnt++;
    send_one(32'h000010E7, 32'h304);             // jalr with funct3=001
    check_cnt++; if (illegal !== 1'b1 || jump_inst !== 1'b0) $display("FAIL ill_jalr: got ill=%0b jump=%0b want 1/0", illegal, jump_inst); else pass_cnt++;
    send_one(32'h0000B083, 32'h308);             // load funct3=011
    check_cnt++; if (illegal !== 1'b1 || mem_read_en !== 1'b0) $display("FAIL ill_load: got ill=%0b mr=%0b want 1/0", illegal, mem_read_en); else pass_cnt++;

    e_in_inst = 32'h002088B3; e_in_valid = 1'b1; e_out_ready = 1'b1;   // add x17,x1,x2
    tick();
    e_in_valid = 1'b0;
    $display("xfer rv32e add x17 -> valid=%0b ill=%0b", e_out_valid, e_illegal);
    check_cnt++; if (e_out_valid !== 1'b1 || e_illegal !== 1'b1) $display("FAIL rv32e_x17: got valid=%0b ill=%0b want 1/1", e_out_valid, e_illegal); else pass_cnt++;
    check_cnt++; if (e_write_en !== 1'b0) $display("FAIL rv32e_x17_we: got %0b want 0", e_write_en); else pass_cnt++;
    e_in_inst = 32'h002083B3; e_in_valid = 1'b1;                      // add x7,x1,x2
    tick();
    e_in_valid = 1'b0;
    $display("xfer rv32e add x7 -> valid=%0b ill=%0b rd=%0d", e_out_valid, e_illegal, e_write_addr);
    check_cnt++; if (e_illegal !== 1'b0 || e_write_addr !== 4'd7 || e_write_en !== 1'b1) $display("FAIL rv32e_x7: got ill=%0b rd=%0d we=%0b want 0/7/1", e_illegal, e_write_addr, e_write_en); else pass_cnt++;
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst = 32'h00100093; in_pc = 32'h400;
    tick();
    in_inst = 32'h00200113; in_pc = 32'h404;
    tick();
    in_inst = 32'h00300193; in_pc = 32'h408;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", out_valid); else pass_cnt++;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %0b want 1", in_ready); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check_cnt++; if (seen != 0) $display("FAIL flush_no_output: got %0d outputs want 0", seen); else pass_cnt++;
    // Handshake on the flush cycle itself must also be dropped.
    in_inst = 32'h00500293; in_pc = 32'h40C; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_handshake: got %0b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_inst = 32'h00100093; in_pc = 32'h500; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_cnt++; if (out_valid !== 1'b1) $display("FAIL rstmid_loaded: got %0b want 1", out_valid); else pass_cnt++;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_async: got valid=%0b ready=%0b want 0/1", out_valid, in_ready); else pass_cnt++;
    check_cnt++; if (write_en !== 1'b0 || out_pc !== 32'h0) $display("FAIL rstmid_outputs: got we=%0b pc=%h want 0/0", write_en, out_pc); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    send_one(32'h402081B3, 32'h600);             // sub x3,x1,x2
    check_cnt++; if (out_valid !== 1'b1 || alu_opcode !== 4'b1000) $display("FAIL sub_alu: got valid=%0b alu=%b want 1/1000", out_valid, alu_opcode); else pass_cnt++;
    check_cnt++; if (write_addr !== 5'd3 || read_addr2 !== 5'd2) $display("FAIL sub_regs: got rd=%0d rs2=%0d want 3/2", write_addr, read_addr2); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_jal();
    test_formats();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
